// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NUM_CH-way valid/ready arbiter (fixed priority or round-robin) feeding a
// one-entry registered output stage. Define RR_ARB_MUX_LOCK_EN to add the lock_i grant lock.

module rr_arb_mux_lane #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data,
  input  logic             sel,
  output logic [WIDTH-1:0] data_sel
);
  assign data_sel = sel ? data : '0;
endmodule

module rr_arb_mux #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_CH = 3,
  parameter  int MODE   = 1,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH*WIDTH-1:0] in_data_i,
  input  logic [NUM_CH-1:0]       in_valid_i,
  output logic [NUM_CH-1:0]       in_ready_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [CH_W-1:0]         out_ch_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic                    lock_i,
`endif
  output logic [15:0]             beat_cnt_o
);

  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
  } gnt_t;

  typedef struct packed {
    logic             vld;
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] data;
  } beat_t;

  gnt_t                          gnt;
  beat_t                         obuf;
  logic [CH_W-1:0]               ptr;
  logic [NUM_CH-1:0]             elig;
  logic [NUM_CH-1:0]             sel;
  logic [NUM_CH-1:0][WIDTH-1:0]  lane_data;
  logic [WIDTH-1:0]              mux_data;
  logic [15:0]                   beat_cnt;
  logic                          can_load;
  logic                          accept;
  logic                          adv;

  assign can_load = !obuf.vld || out_ready_i;
  assign accept   = gnt.vld && can_load && !rst_i;

`ifdef RR_ARB_MUX_LOCK_EN
  logic            locked;
  logic [CH_W-1:0] lock_ch;

  // A held lock masks every other channel, even while the owner is idle.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_CH; k++)
      elig[k] = in_valid_i[k] && (!locked || lock_ch == CH_W'(k));
  end

  assign adv = !lock_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (accept) begin
      locked  <= lock_i;
      lock_ch <= gnt.ch;
    end
  end
`else
  assign elig = in_valid_i;
  assign adv  = 1'b1;
`endif

  // Rotating search from ptr; the wrap subtract keeps non-power-of-2 sizes in range.
  always_comb begin
    logic [CH_W:0] idx;
    idx = '0;
    gnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (MODE == 1) ? ({1'b0, ptr} + (CH_W+1)'(i)) : (CH_W+1)'(i);
      if (idx >= (CH_W+1)'(NUM_CH))
        idx = idx - (CH_W+1)'(NUM_CH);
      if (!gnt.vld && elig[idx[CH_W-1:0]]) begin
        gnt.vld = 1'b1;
        gnt.ch  = idx[CH_W-1:0];
      end
    end
  end

  always_comb begin
    sel = '0;
    if (gnt.vld)
      sel[gnt.ch] = 1'b1;
  end

  assign in_ready_o = (can_load && !rst_i) ? sel : '0;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    rr_arb_mux_lane #(.WIDTH(WIDTH)) u_lane (
      .data     (in_data_i[k*WIDTH +: WIDTH]),
      .sel      (sel[k]),
      .data_sel (lane_data[k])
    );
  end

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      mux_data = mux_data | lane_data[k];
  end

  if (MODE == 1) begin : g_rr
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
        ptr <= '0;
      else if (accept && adv)
        ptr <= (gnt.ch == CH_W'(NUM_CH-1)) ? '0 : gnt.ch + CH_W'(1);
    end
  end else begin : g_fp
    assign ptr = '0;
  end

  // Drain and refill on the same edge keeps back-to-back traffic bubble free.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      obuf <= '0;
    else if (accept)
      obuf <= '{vld: 1'b1, ch: gnt.ch, data: mux_data};
    else if (out_ready_i)
      obuf.vld <= 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      beat_cnt <= '0;
    else if (obuf.vld && out_ready_i)
      beat_cnt <= beat_cnt + 16'd1;
  end

  assign out_valid_o = obuf.vld;
  assign out_ch_o    = obuf.ch;
  assign out_data_o  = obuf.data;
  assign beat_cnt_o  = beat_cnt;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: a round-robin and a fixed-priority instance, each checked every
// cycle against a queue-free behavioural model, plus directed literal expectations.
module tb_rr_arb_mux;
  localparam int W = 32;
  localparam int N = 3;
`ifdef RR_ARB_MUX_LOCK_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0][W-1:0] d_rr, d_fp;
  logic [N-1:0]        v_rr, v_fp, rdy_rr, rdy_fp;
  logic [W-1:0]        od_rr, od_fp;
  logic [1:0]          och_rr, och_fp;
  logic                ov_rr, ov_fp, ordy_rr, ordy_fp, lock;
  logic [15:0]         cnt_rr, cnt_fp;

  rr_arb_mux #(.WIDTH(W), .NUM_CH(N), .MODE(1)) dut_rr (
    .clk_i(clk), .rst_i(rst), .in_data_i(d_rr), .in_valid_i(v_rr), .in_ready_o(rdy_rr),
    .out_data_o(od_rr), .out_ch_o(och_rr), .out_valid_o(ov_rr), .out_ready_i(ordy_rr),
`ifdef RR_ARB_MUX_LOCK_EN
    .lock_i(lock),
`endif
    .beat_cnt_o(cnt_rr));

  rr_arb_mux #(.WIDTH(W), .NUM_CH(N), .MODE(0)) dut_fp (
    .clk_i(clk), .rst_i(rst), .in_data_i(d_fp), .in_valid_i(v_fp), .in_ready_o(rdy_fp),
    .out_data_o(od_fp), .out_ch_o(och_fp), .out_valid_o(ov_fp), .out_ready_i(ordy_fp),
`ifdef RR_ARB_MUX_LOCK_EN
    .lock_i(lock),
`endif
    .beat_cnt_o(cnt_fp));

  typedef struct {
    bit          vld;
    logic [31:0] data;
    int          ch;
    int          cnt;
    int          ptr;
    bit          lk;
    int          lk_ch;
    bit          acc;
    int          acc_ch;
  } mdl_t;

  mdl_t m_rr, m_fp;
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.vld = 0; m.data = '0; m.ch = 0; m.cnt = 0; m.ptr = 0;
    m.lk = 0; m.lk_ch = 0; m.acc = 0; m.acc_ch = 0;
    return m;
  endfunction

  // Scan order: from ptr with modulo wrap for round-robin, from 0 for fixed priority.
  function automatic int pick(input logic [N-1:0] v, input int p, input bit rr,
                              input bit lk, input int lk_ch);
    for (int i = 0; i < N; i++) begin
      int c;
      c = rr ? (p + i) % N : i;
      if (v[c] && (!lk || c == lk_ch)) return c;
    end
    return -1;
  endfunction

  task automatic step_model(input string nm, inout mdl_t m, input logic [N-1:0] v,
                            input logic [N-1:0][W-1:0] d, input bit ordy, input bit rr,
                            input bit lki, input logic [N-1:0] rdy, input logic ov,
                            input logic [W-1:0] od, input logic [1:0] och, input logic [15:0] cnt);
    int g;
    int er;
    g  = pick(v, m.ptr, rr, m.lk, m.lk_ch);
    er = (g >= 0 && (!m.vld || ordy)) ? (1 << g) : 0;
    chk({nm, ".in_ready"}, 32'(rdy), 32'(er));
    chk({nm, ".out_valid"}, 32'(ov), 32'(m.vld));
    chk({nm, ".out_data"}, od, m.data);
    chk({nm, ".out_ch"}, 32'(och), 32'(m.ch));
    chk({nm, ".beat_cnt"}, 32'(cnt), 32'(m.cnt));
    if (m.vld && ordy) m.cnt = (m.cnt + 1) % 65536;
    m.acc    = (er != 0);
    m.acc_ch = g;
    if (m.acc) begin
      m.vld  = 1;
      m.data = d[g];
      m.ch   = g;
      if (lki) begin
        m.lk = 1; m.lk_ch = g;
      end else begin
        m.lk = 0;
        if (rr) m.ptr = (g + 1) % N;
      end
    end else if (ordy) begin
      m.vld = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_rr = mdl_reset();
      m_fp = mdl_reset();
      chk("rst.in_ready_rr", 32'(rdy_rr), 32'd0);
      chk("rst.in_ready_fp", 32'(rdy_fp), 32'd0);
      chk("rst.out_valid_rr", 32'(ov_rr), 32'd0);
    end else begin
      step_model("rr", m_rr, v_rr, d_rr, ordy_rr, 1'b1, LK && lock, rdy_rr, ov_rr, od_rr, och_rr, cnt_rr);
      step_model("fp", m_fp, v_fp, d_fp, ordy_fp, 1'b0, LK && lock, rdy_fp, ov_fp, od_fp, och_fp, cnt_fp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic src(inout logic [N-1:0] v, inout logic [N-1:0][W-1:0] d, input mdl_t m);
    for (int k = 0; k < N; k++) begin
      if (m.acc && m.acc_ch == k) begin
        v[k] = 1'($urandom_range(0, 1));
        d[k] = $urandom;
      end else if (!v[k] && $urandom_range(0, 2) == 0) begin
        v[k] = 1'b1;
        d[k] = $urandom;
      end
    end
  endtask

  initial begin
    v_rr = '0; v_fp = '0; ordy_rr = 1'b1; ordy_fp = 1'b1; lock = 1'b0;
    for (int k = 0; k < N; k++) begin
      d_rr[k] = 32'hA0 + 32'(k);
      d_fp[k] = 32'hA0 + 32'(k);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // round-robin order from ptr=0, fixed priority always ch0
    v_rr = 3'b111; v_fp = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_order", 32'(och_rr), 32'(i % 3));
      chk("rr_no_bubble", 32'(ov_rr), 32'd1);
      chk("fp_prio", 32'(och_fp), 32'd0);
    end
    v_fp = 3'b110;
    tick();
    chk("fp_next", 32'(och_fp), 32'd1);
    chk("rr_7th", 32'(och_rr), 32'd0);
    chk("rr_cnt6", 32'(cnt_rr), 32'd6);

    // backpressure: held beat stable, no ready, then drain+refill on one edge
    ordy_rr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(rdy_rr), 32'd0);
      tick();
      chk("stall_data", od_rr, 32'hA0);
      chk("stall_valid", 32'(ov_rr), 32'd1);
    end
    ordy_rr = 1'b1;
    tick();
    chk("refill_ch", 32'(och_rr), 32'd1);
    chk("refill_data", od_rr, 32'hA1);
    chk("refill_valid", 32'(ov_rr), 32'd1);
    chk("refill_cnt", 32'(cnt_rr), 32'd7);

    // asynchronous reset mid-transfer
    #2 rst = 1'b1;
    #1;
    chk("areset_valid", 32'(ov_rr), 32'd0);
    chk("areset_data", od_rr, 32'd0);
    chk("areset_ch", 32'(och_rr), 32'd0);
    chk("areset_cnt", 32'(cnt_rr), 32'd0);
    chk("areset_ready", 32'(rdy_rr), 32'd0);
    v_rr = '0; v_fp = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("release_valid", 32'(ov_rr), 32'd0);

    // single channel, ptr moves to 2
    v_rr = 3'b010; d_rr[1] = 32'hDEADBEEF;
    tick();
    chk("single_data", od_rr, 32'hDEADBEEF);
    chk("single_ch", 32'(och_rr), 32'd1);
    chk("single_cnt0", 32'(cnt_rr), 32'd0);
    v_rr = '0;
    tick();
    chk("single_cnt1", 32'(cnt_rr), 32'd1);
    chk("drain_valid", 32'(ov_rr), 32'd0);
    chk("drain_hold", od_rr, 32'hDEADBEEF);
    v_rr = 3'b101;
    tick();
    chk("ptr_is_2", 32'(och_rr), 32'd2);
    v_rr = '0;
    tick();

`ifdef RR_ARB_MUX_LOCK_EN
    // ptr=0 here; one ch1 beat moves it to 2, then ch2 locks out ch0
    v_rr = 3'b010;
    tick();
    v_rr = 3'b101; lock = 1'b1;
    @(negedge clk);
    chk("lock_first_ready", 32'(rdy_rr), 32'd4);
    tick();
    chk("lock_first_ch", 32'(och_rr), 32'd2);
    v_rr = 3'b001;
    @(negedge clk);
    chk("lock_idle_ready", 32'(rdy_rr), 32'd0);
    tick();
    v_rr = 3'b101;
    tick();
    chk("lock_second_ch", 32'(och_rr), 32'd2);
    lock = 1'b0;
    tick();
    chk("unlock_ch", 32'(och_rr), 32'd2);
    tick();
    chk("after_unlock_ch", 32'(och_rr), 32'd0);
    v_rr = '0;
    tick();
`endif

    // randomized traffic against the model
    v_fp = '0;
    for (int i = 0; i < 3000; i++) begin
      src(v_rr, d_rr, m_rr);
      src(v_fp, d_fp, m_fp);
      ordy_rr = ($urandom_range(0, 3) != 0);
      ordy_fp = ($urandom_range(0, 3) != 0);
      lock    = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised successor to the pipeline's N-way data selectors.
- Selects one of NUM_CH valid/ready source channels per cycle and registers the chosen word into a single-entry output stage with valid/ready handshake.
- Sits in front of shared datapath resources, e.g. the writeback or memory-request port, where several pipeline stages compete for the resource.
- Arbitration is fixed-priority or round-robin, chosen by parameter; a wrapping delivered-beat counter is kept for debug.

Parameters:
- WIDTH, 32, data width per channel in bits.
- NUM_CH, 3, number of source channels; legal range 2..16.
- MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- in_data_i  input  NUM_CH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid_i  input  NUM_CH  per-channel valid.
- in_ready_o  output  NUM_CH  per-channel ready; at most one bit high per cycle.
- out_data_o  output  WIDTH  registered selected data.
- out_ch_o  output  CH_W  index of the channel whose data is in the output register.
- out_valid_o  output  1  output register holds a beat.
- out_ready_i  input  1  downstream accepts the beat.
- beat_cnt_o  output  16  count of beats delivered downstream (out_valid_o && out_ready_i); wraps.

Behaviour:
- CH_W = max(1, $clog2(NUM_CH)), a local parameter.
- Reset (rst_i high, asynchronous):
  - out_valid_o=0, out_data_o=0, out_ch_o=0, beat_cnt_o=0.
  - Round-robin pointer ptr=0.
  - in_ready_o=0 while rst_i is high.
- Reset asserted mid-transfer discards the held beat. No beat is emitted on the reset-release cycle.
- can_load = !out_valid_o || out_ready_i. This gives full throughput, one beat per cycle, with no bubble on back-to-back traffic.
- Grant is combinational from in_valid_i and ptr:
  - MODE 0: lowest-index valid channel.
  - MODE 1: first valid channel found searching ptr, ptr+1, ... NUM_CH-1, 0, ... ptr-1.
  - No valid channel means no grant.
- in_ready_o[g] = can_load && grant valid, for the granted index g; all other bits are 0.
  - in_ready_o never depends on out_ready_i except through can_load.
  - No combinational path exists from in_valid_i to in_ready_o of a different channel's acceptance decision beyond the grant logic.
- Accept event (in_valid_i[g] && in_ready_o[g]), at the next edge:
  - out_data_o <= channel g data, out_ch_o <= g, out_valid_o <= 1.
  - MODE 1 only: ptr <= (g+1) mod NUM_CH. ptr wraps at NUM_CH; non-power-of-2 NUM_CH must never select an index >= NUM_CH.
- Latency: input accept to out_valid_o is 1 cycle.
- Drain without refill: when out_valid_o && out_ready_i with no accept, out_valid_o <= 0. out_data_o and out_ch_o hold their last values.
- Stall: while out_valid_o && !out_ready_i, out_data_o and out_ch_o are stable and all in_ready_o are 0.
- Simultaneous drain and accept in the same cycle: the new beat replaces the old one and out_valid_o stays 1.
- ptr changes only on accept. ptr is unused in MODE 0 and stays at 0.
- beat_cnt_o increments by 1 on each delivered beat and wraps 16'hFFFF -> 0.
- Sources obey standard valid/ready: once in_valid_i[k] is asserted, data is held until accepted. The block does not check this.

Optional Feature:
- Macro RR_ARB_MUX_LOCK_EN.
- Defined:
  - Adds input lock_i (1 bit), qualified with the accepted beat.
  - If lock_i=1 on an accept from channel g, a lock is set on g. While locked, only channel g may be granted and other channels see in_ready_o=0, even if g is idle.
  - The lock clears on the next accept from g with lock_i=0.
  - ptr does not advance while a locked beat is accepted; it advances normally on the unlocking beat.
  - Reset clears the lock.
- Not defined: no lock_i port, no lock state, behaviour exactly as above.

Test Plan:
- Reset/idle: assert rst_i mid-stream with out_valid_o=1 -> out_valid_o=0, out_data_o=0, beat_cnt_o=0 immediately (before the next edge). Every in_ready_o stays 0 while rst_i is high.
- Single channel, MODE 1, NUM_CH=3:
  - ch1 valid with 32'hDEADBEEF, out_ready_i=1.
  - One cycle later out_data_o=32'hDEADBEEF, out_ch_o=1.
  - ptr becomes 2; beat_cnt_o=1 the following cycle.
- Round-robin fairness, MODE 1: all 3 channels valid continuously with out_ready_i=1 -> grant order 0,1,2,0,1,2, one beat per cycle, no bubbles.
- Fixed priority, MODE 0: all 3 channels valid -> ch0 granted every cycle. Drop ch0 valid -> ch1 granted.
- Backpressure:
  - out_ready_i=0 for 4 cycles with out_valid_o=1 -> out_data_o stable, in_ready_o=0.
  - Raise out_ready_i -> held beat delivered and the next beat loaded in the same edge.
- Lock (RR_ARB_MUX_LOCK_EN, MODE 1):
  - ch2 beats with lock_i=1,1,0 while ch0 is valid -> ch0 gets no grant until after the third ch2 beat.
  - Next grant is ch0.
